// File: rtl/rob_pkg.sv
// Shared ROB types and default widths.
// Imported by the ROB, issue stage and reservation stations.
package rob_pkg;

  localparam int ROB_WIDTH_DEF  = 4;
  localparam int REG_WIDTH_DEF  = 5;
  localparam int DATA_WIDTH_DEF = 32;

  typedef struct packed {
    logic                      busy;
    logic                      ready;
    logic [REG_WIDTH_DEF-1:0]  rd_id;
    logic [DATA_WIDTH_DEF-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrapping pointer with increment enable and clear.
// Ports: clk_in, rst_n_in (sync, low), clr_in, en_in, ptr_o.
module rob_ptr #(
  parameter int W = 4
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         clr_in,
  input  logic         en_in,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_in)
      ptr_d = '0;
    else if (en_in)
      ptr_d = ptr_q + W'(1);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in)
      ptr_q <= '0;
    else
      ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tag allocation, CDB capture,
// in-order commit port and operand readiness lookups.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int ROB_WIDTH  = ROB_WIDTH_DEF,
  parameter int REG_WIDTH  = REG_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  issue_valid,
  input  logic [REG_WIDTH-1:0]  issue_rd_id,
  output logic                  issue_ready,
  output logic [ROB_WIDTH-1:0]  issue_tag,
  input  logic                  wb_valid,
  input  logic [ROB_WIDTH-1:0]  wb_tag,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic [ROB_WIDTH-1:0]  query_tag_1,
  input  logic [ROB_WIDTH-1:0]  query_tag_2,
  output logic                  query_ready_1,
  output logic                  query_ready_2,
  output logic [DATA_WIDTH-1:0] query_data_1,
  output logic [DATA_WIDTH-1:0] query_data_2,
  input  logic                  flush_in,
  output logic                  rob_commit_signal,
  output logic [REG_WIDTH-1:0]  commit_rd_id,
  output logic [DATA_WIDTH-1:0] commit_rd_data,
  output logic [ROB_WIDTH-1:0]  commit_rd_tag,
  output logic                  rob_empty
);

  localparam int DEPTH = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] FULL_CNT =
    {1'b1, {ROB_WIDTH{1'b0}}};

  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [DEPTH-1:0]      ready_q, ready_d;
  logic [REG_WIDTH-1:0]  rd_q   [DEPTH];
  logic [REG_WIDTH-1:0]  rd_d   [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [ROB_WIDTH:0]    count_q, count_d;

  logic                  cv_q, cv_d;
  logic [REG_WIDTH-1:0]  crd_q, crd_d;
  logic [DATA_WIDTH-1:0] cdata_q, cdata_d;
  logic [ROB_WIDTH-1:0]  ctag_q, ctag_d;

  logic [ROB_WIDTH-1:0]  head, tail;
  logic full, live;
  logic do_issue, do_wb, do_commit, ptr_clr;
  logic q1_hit, q2_hit;

  assign full      = (count_q == FULL_CNT);
  assign live      = rdy_in & ~flush_in;
  assign do_issue  = live & issue_valid & ~full;
  assign do_wb     = live & wb_valid
                   & busy_q[wb_tag] & ~ready_q[wb_tag];
  assign do_commit = live & busy_q[head] & ready_q[head];
  assign ptr_clr   = rdy_in & flush_in;

  rob_ptr #(.W(ROB_WIDTH)) u_head (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .clr_in   (ptr_clr),
    .en_in    (do_commit),
    .ptr_o    (head)
  );

  rob_ptr #(.W(ROB_WIDTH)) u_tail (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .clr_in   (ptr_clr),
    .en_in    (do_issue),
    .ptr_o    (tail)
  );

  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    rd_d    = rd_q;
    data_d  = data_q;
    count_d = count_q;
    cv_d    = cv_q;
    crd_d   = crd_q;
    cdata_d = cdata_q;
    ctag_d  = ctag_q;
    if (rdy_in) begin
      if (flush_in) begin
        busy_d  = '0;
        ready_d = '0;
        count_d = '0;
        cv_d    = 1'b0;
      end else begin
        cv_d = 1'b0;
        if (do_wb) begin
          ready_d[wb_tag] = 1'b1;
          data_d[wb_tag]  = wb_data;
        end
        if (do_commit) begin
          busy_d[head] = 1'b0;
          cv_d         = 1'b1;
          crd_d        = rd_q[head];
          cdata_d      = data_q[head];
          ctag_d       = head;
        end
        // tail never aliases a busy slot unless full,
        // in which case issue is already blocked
        if (do_issue) begin
          busy_d[tail]  = 1'b1;
          ready_d[tail] = 1'b0;
          rd_d[tail]    = issue_rd_id;
          data_d[tail]  = '0;
        end
        count_d = count_q
                + (ROB_WIDTH+1)'(do_issue)
                - (ROB_WIDTH+1)'(do_commit);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      busy_q  <= '0;
      ready_q <= '0;
      count_q <= '0;
      cv_q    <= 1'b0;
      crd_q   <= '0;
      cdata_q <= '0;
      ctag_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      ready_q <= ready_d;
      count_q <= count_d;
      cv_q    <= cv_d;
      crd_q   <= crd_d;
      cdata_q <= cdata_d;
      ctag_q  <= ctag_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  // same-cycle CDB forwarding into operand lookups
  assign q1_hit = wb_valid & (wb_tag == query_tag_1);
  assign q2_hit = wb_valid & (wb_tag == query_tag_2);

  always_comb begin
    query_ready_1 = 1'b0;
    query_data_1  = '0;
    query_ready_2 = 1'b0;
    query_data_2  = '0;
    if (busy_q[query_tag_1]) begin
      query_ready_1 = ready_q[query_tag_1] | q1_hit;
      query_data_1  = q1_hit ? wb_data
                             : data_q[query_tag_1];
    end
    if (busy_q[query_tag_2]) begin
      query_ready_2 = ready_q[query_tag_2] | q2_hit;
      query_data_2  = q2_hit ? wb_data
                             : data_q[query_tag_2];
    end
  end

  assign issue_ready       = ~full;
  assign issue_tag         = tail;
  assign rob_empty         = (count_q == '0);
  assign rob_commit_signal = cv_q;
  assign commit_rd_id      = crd_q;
  assign commit_rd_data    = cdata_q;
  assign commit_rd_tag     = ctag_q;

endmodule
